// File: rtl/ser_pkg.sv
// Shared definitions for the bit serializer and its bit counter: FSM state
// encoding and the default frame width.
package ser_pkg;

    localparam int SER_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } ser_state_e;

endpackage

// File: rtl/ser_bit_cnt.sv
// Up-counter with clear/load/enable and a terminal-count flag at WIDTH-1.
// Clear has priority over load, load over enable.
module ser_bit_cnt #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    logic [CW-1:0] cnt_r;

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en) begin
            cnt_r <= cnt_r + CW'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;
    assign tc  = (cnt_r == CW'(WIDTH - 1));

endmodule

// File: rtl/bit_serializer.sv
// Parallel-in, MSB-first serial-out source with valid/ready intake and a
// frame_done pulse. Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int   WIDTH      = SER_WIDTH_DEF,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             dout,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = $clog2(WIDTH);

    ser_state_e       state_r, state_nxt_s;
    logic [WIDTH-1:0] shreg_r, shreg_nxt_s;
    logic [CW-1:0]    cnt_s;
    logic             cnt_unused_s;
    logic             tc_s, cnt_clr_s, cnt_en_s;
    logic             accept_s, done_nxt_s, dout_nxt_s;

`ifdef BIT_SERIALIZER_PARITY_EN
    logic par_r;

    function automatic logic even_parity(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction

    // Parity of the accepted word, replayed as the frame's final bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_r <= 1'b0;
        end else if (accept_s) begin
            par_r <= even_parity(data_in);
        end else begin
            par_r <= par_r;
        end
    end
`endif

    ser_bit_cnt #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr_s),
        .load     (1'b0),
        .load_val ({CW{1'b0}}),
        .en       (cnt_en_s),
        .cnt      (cnt_s),
        .tc       (tc_s)
    );

    // Only the terminal flag steers the FSM; the raw count is for other users.
    assign cnt_unused_s = ^cnt_s;
    assign accept_s     = (state_r == S_IDLE) && valid_in;

    // State and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            shreg_r <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            shreg_r <= shreg_nxt_s;
        end
    end

    // Next-state, shift and counter control.
    always_comb begin
        state_nxt_s = state_r;
        shreg_nxt_s = shreg_r;
        cnt_clr_s   = 1'b0;
        cnt_en_s    = 1'b0;
        done_nxt_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = S_SHIFT;
                    shreg_nxt_s = data_in;
                    cnt_clr_s   = 1'b1;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_SHIFT: begin
                shreg_nxt_s = {shreg_r[WIDTH-2:0], 1'b0};
                if (tc_s) begin
`ifdef BIT_SERIALIZER_PARITY_EN
                    state_nxt_s = S_PARITY;
`else
                    state_nxt_s = S_IDLE;
                    done_nxt_s  = 1'b1;
`endif
                end else begin
                    cnt_en_s = 1'b1;
                end
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            S_PARITY: begin
                state_nxt_s = S_IDLE;
                done_nxt_s  = 1'b1;
            end
`endif
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Output bit for the upcoming cycle, derived from the upcoming state.
    always_comb begin
        dout_nxt_s = IDLE_LEVEL;
        case (state_nxt_s)
            S_SHIFT:  dout_nxt_s = shreg_nxt_s[WIDTH-1];
`ifdef BIT_SERIALIZER_PARITY_EN
            S_PARITY: dout_nxt_s = par_r;
`endif
            default:  dout_nxt_s = IDLE_LEVEL;
        endcase
    end

    // Registered Moore outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_out  <= 1'b1;
            busy       <= 1'b0;
            dout       <= IDLE_LEVEL;
            frame_done <= 1'b0;
        end else begin
            ready_out  <= (state_nxt_s == S_IDLE);
            busy       <= (state_nxt_s != S_IDLE);
            dout       <= dout_nxt_s;
            frame_done <= done_nxt_s;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: directed literal frames plus random
// traffic checked every cycle against a queue-based frame model.
module tb_bit_serializer;

    localparam int   W    = 8;
    localparam logic IDLE = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int   PAR  = 1;
`else
    localparam int   PAR  = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] data_in = '0;
    logic         valid_in = 1'b0;
    logic         ready_out, dout, busy, frame_done;

    int checks   = 0;
    int failures = 0;

    // Model: bits still to appear on dout (front = current cycle), plus done flag.
    logic mq[$];
    logic m_done = 1'b0;

    bit_serializer #(.WIDTH(W), .IDLE_LEVEL(IDLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .dout       (dout),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one edge using the inputs that the edge will see.
    task automatic model_edge();
        if (rst) begin
            mq.delete();
            m_done = 1'b0;
        end else if (mq.size() != 0) begin
            void'(mq.pop_front());
            m_done = (mq.size() == 0);
        end else begin
            m_done = 1'b0;
            if (valid_in) begin
                for (int i = W - 1; i >= 0; i--) mq.push_back(data_in[i]);
                if (PAR == 1) mq.push_back(^data_in);
            end
        end
    endtask

    task automatic compare_model();
        logic mb;
        mb = (mq.size() != 0);
        chk("model_busy",  busy,       mb);
        chk("model_ready", ready_out,  !mb);
        chk("model_dout",  dout,       mb ? mq[0] : IDLE);
        chk("model_done",  frame_done, m_done);
    endtask

    // One clock: model update, edge, then sample at the falling edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    // Serialize one word and pin its bit stream and frame_done against literals.
    task automatic frame_literal(input logic [W-1:0] word, input logic [W-1:0] bits,
                                 input logic par_bit, input string tag);
        valid_in = 1'b1;
        data_in  = word;
        tick();
        valid_in = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            chk({tag, "_bit"},   dout, bits[i]);
            chk({tag, "_ready"}, ready_out, 1'b0);
            chk({tag, "_busy"},  busy, 1'b1);
            tick();
        end
        if (PAR == 1) begin
            chk({tag, "_par"}, dout, par_bit);
            tick();
        end
        chk({tag, "_done"},      frame_done, 1'b1);
        chk({tag, "_idle_dout"}, dout, IDLE);
        tick();
        chk({tag, "_done_clr"},  frame_done, 1'b0);
    endtask

    initial begin
        logic [W-1:0] lit;
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("rst_ready", ready_out, 1'b1);
        chk("rst_dout",  dout, 1'b0);
        chk("rst_busy",  busy, 1'b0);
        chk("rst_done",  frame_done, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // A5 MSB-first, even parity 0.
        lit = 8'b1010_0101;
        frame_literal(8'hA5, lit, 1'b0, "a5");

        // Back-to-back FF then 00: second accept on the frame_done cycle.
        valid_in = 1'b1;
        data_in  = 8'hFF;
        tick();
        data_in  = 8'h00;
        for (int c = 1; c <= W + PAR; c++) begin
            chk("b2b_ff_bit", dout, (c <= W) ? 1'b1 : 1'b0);
            tick();
        end
        chk("b2b_done1", frame_done, 1'b1);
        chk("b2b_ready", ready_out, 1'b1);
        chk("b2b_gap",   dout, 1'b0);
        tick();
        valid_in = 1'b0;
        for (int c = 1; c <= W + PAR; c++) begin
            chk("b2b_00_bit",  dout, 1'b0);
            chk("b2b_00_busy", busy, 1'b1);
            tick();
        end
        chk("b2b_done2", frame_done, 1'b1);
        tick();

        // data_in changes mid-frame with valid high: stream stays A5.
        valid_in = 1'b1;
        data_in  = 8'hA5;
        tick();
        data_in  = 8'h3C;
        lit = 8'b1010_0101;
        for (int i = W - 1; i >= 0; i--) begin
            chk("hold_bit", dout, lit[i]);
            if (i == 0 && PAR == 0) valid_in = 1'b0;
            tick();
        end
        if (PAR == 1) begin
            chk("hold_par", dout, 1'b0);
            valid_in = 1'b0;
            tick();
        end
        chk("hold_done", frame_done, 1'b1);
        tick();
        chk("hold_no_extra", busy, 1'b0);

        // Reset after bit 3 of F0 discards the frame.
        valid_in = 1'b1;
        data_in  = 8'hF0;
        tick();
        valid_in = 1'b0;
        tick();
        tick();
        chk("rstmid_bit3", dout, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_dout",  dout, 1'b0);
        chk("rstmid_busy",  busy, 1'b0);
        chk("rstmid_ready", ready_out, 1'b1);
        chk("rstmid_done",  frame_done, 1'b0);
        for (int c = 0; c < W + 2; c++) begin
            chk("rstmid_nodone", frame_done, 1'b0);
            tick();
        end

        // 07: parity bit 1 when compiled in.
        lit = 8'b0000_0111;
        frame_literal(8'h07, lit, 1'b1, "p07");

        // Reset wins over a simultaneous accept.
        valid_in = 1'b1;
        data_in  = 8'hC3;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        valid_in = 1'b0;
        chk("rst_prio_busy", busy, 1'b0);
        tick();

        // Random traffic checked against the model every cycle.
        for (int n = 0; n < 2000; n++) begin
            valid_in = ($urandom_range(0, 99) < 55);
            data_in  = W'($urandom);
            rst      = ($urandom_range(0, 99) < 2);
            tick();
        end
        rst      = 1'b0;
        valid_in = 1'b0;
        repeat (W + 3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
